simon_key_schedule: RTL

Round-key generator for the SIMON32/64 mixed-model core. Accepts a 64-bit master key, then emits the 32 round keys in groups of `mixed_size` words per cycle, exactly the `key_in` bundle consumed by the downstream pipe section. The key window is registered and the SIMON key recurrence is unrolled `mixed_size` times per step. Output delivery is flow-controlled with a valid/ready handshake.

---
 rtl/simon_key_schedule.sv | 129 ++++++++++++
 1 files changed

// File: rtl/simon_key_schedule.sv
// rtl/simon_key_schedule.sv - SIMON32/64 round-key generator emitting mixed_size keys per group (optional SIMON_KSCHED_REPLAY_EN)
module simon_key_schedule #(
    parameter int mixed_size = 8,
    localparam int num_groups = 32 / mixed_size,
    localparam int grp_w = (num_groups > 1) ? $clog2(num_groups) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef SIMON_KSCHED_REPLAY_EN
    input  logic                        replay,
`endif
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [63:0]                 master_key,
    output logic [mixed_size-1:0][15:0] rk_out,
    output logic                        rk_valid,
    input  logic                        rk_ready,
    output logic [grp_w-1:0]            rk_group,
    output logic                        rk_last
);

    // z0 sequence; leftmost character (index 0) is the MSB of this constant
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam int ext_n = mixed_size + 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [3:0][15:0]  window;
    logic [5:0]        counter;
    logic [3:0][15:0]  src;
    logic [5:0]        base;
    logic [5:0]        zi;
    logic [15:0]       ext [ext_n];
    logic              start;
    logic [63:0]       start_key;

`ifdef SIMON_KSCHED_REPLAY_EN
    logic [63:0]       shadow;
    assign start     = load_ready && (load_valid || replay);
    assign start_key = load_valid ? master_key : shadow;
`else
    assign start     = load_ready && load_valid;
    assign start_key = master_key;
`endif

    assign rk_last = rk_valid && (rk_group == grp_w'(num_groups - 1));

    // One step of the SIMON key recurrence; the z bit only touches bit 0
    function automatic logic [15:0] next_key(input logic [15:0] km1, input logic [15:0] km3,
                                             input logic [15:0] km4, input logic zb);
        logic [15:0] t;
        t = {km1[2:0], km1[15:3]} ^ km3;
        t = t ^ {t[0], t[15:1]};
        return 16'hFFFC ^ {15'b0, zb} ^ km4 ^ t;
    endfunction

    // Window feeding the unrolled chain: start key at round 0 in IDLE, slid window in RUN
    always_comb begin
        if (state == IDLE) begin
            src  = start_key;
            base = 6'd0;
        end else begin
            src  = window;
            base = counter;
        end
    end

    // Unrolled recurrence: first four words straight from the window, the rest chained in-cycle
    always_comb begin
        zi = 6'd0;
        for (int j = 0; j < ext_n; j++) ext[j] = 16'h0000;
        for (int j = 0; j < 4; j++) ext[j] = src[j];
        for (int j = 4; j < ext_n; j++) begin
            zi     = base + 6'(j - 4);
            ext[j] = next_key(ext[j-1], ext[j-3], ext[j-4], Z0[6'd61 - zi]);
        end
    end

    // Control FSM with registered group, window and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            load_ready <= 1'b0;
            rk_valid   <= 1'b0;
            rk_out     <= '0;
            rk_group   <= '0;
            window     <= '0;
            counter    <= '0;
`ifdef SIMON_KSCHED_REPLAY_EN
            shadow     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    load_ready <= 1'b1;
                    if (start) begin
                        for (int j = 0; j < mixed_size; j++) rk_out[j] <= ext[j];
                        for (int j = 0; j < 4; j++) window[j] <= ext[mixed_size + j];
                        counter    <= 6'(mixed_size);
                        rk_group   <= '0;
                        rk_valid   <= 1'b1;
                        load_ready <= 1'b0;
                        state      <= RUN;
`ifdef SIMON_KSCHED_REPLAY_EN
                        if (load_valid) shadow <= master_key;
`endif
                    end
                end
                RUN: begin
                    if (rk_ready) begin
                        if (rk_group == grp_w'(num_groups - 1)) begin
                            state      <= IDLE;
                            rk_valid   <= 1'b0;
                            rk_group   <= '0;
                            load_ready <= 1'b1;
                        end else begin
                            for (int j = 0; j < mixed_size; j++) rk_out[j] <= ext[j];
                            for (int j = 0; j < 4; j++) window[j] <= ext[mixed_size + j];
                            counter  <= counter + 6'(mixed_size);
                            rk_group <= rk_group + grp_w'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
